// File: rtl/clk_div_gen.sv
// Programmable clock divider: divides clk1 by a loadable ratio N,
// with a registered square wave, end-of-period tick and load/ack handshake.
//
// Ports:
//   clk1      system clock, all state changes on its rising edge
//   rst1      asynchronous reset, active-high
//   en        run request (level)
//   div_ratio requested ratio N, sampled when load=1
//   load      ratio-load request
//   load_ack  one-cycle acknowledge of a captured load
//   out1      divided clock, high for floor(N/2) cycles of each period
//   tick      high in the last clk1 cycle of each out1 period
//   busy      high while running
module clk_div_gen #(
    parameter int DIV_W   = 8,
    parameter int DEF_DIV = 2
) (
    input  logic             clk1,
    input  logic             rst1,
    input  logic             en,
    input  logic [DIV_W-1:0] div_ratio,
    input  logic             load,
    output logic             load_ack,
    output logic             out1,
    output logic             tick,
    output logic             busy
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [DIV_W-1:0] ONE   = DIV_W'(1);
    localparam logic [DIV_W-1:0] TWO   = DIV_W'(2);
    localparam logic [DIV_W-1:0] DEF_R = DIV_W'(DEF_DIV);

    state_t           state_q;
    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] ratio_q;
    logic [DIV_W-1:0] pend_q;
    logic             pend_vld_q;
    logic             out1_q;
    logic             tick_q;
    logic             busy_q;
    logic             ack_q;

    logic             wrap;
    logic             boundary;
    logic             run_d;
    logic [DIV_W-1:0] cnt_d;
    logic [DIV_W-1:0] ratio_d;
    logic [DIV_W-1:0] pend_d;
    logic             pend_vld_d;
    logic             out1_d;
    logic             tick_d;
    logic [DIV_W-1:0] clamped;

    always_comb begin
        clamped = (div_ratio < TWO) ? TWO : div_ratio;

        // A boundary is any edge where a new period may begin:
        // every edge while idle, or the wrap edge while running.
        wrap     = (state_q == RUN) && (cnt_q == ratio_q - ONE);
        boundary = (state_q == IDLE) || wrap;

        // Pending ratio only lands on a boundary, so a period never
        // mixes two ratios. A load captured on this same edge is not
        // visible in pend_vld_q yet and waits for the next boundary.
        ratio_d = ratio_q;
        if (boundary && pend_vld_q) begin
            ratio_d = pend_q;
        end

        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        if (boundary) begin
            pend_vld_d = 1'b0;
        end
        if (load) begin
            pend_d     = clamped;
            pend_vld_d = 1'b1;
        end

        run_d = boundary ? en : 1'b1;
        cnt_d = boundary ? '0 : cnt_q + ONE;

        // Outputs are computed from the next count so they are
        // registered yet aligned with the cycle they describe.
        out1_d = run_d && (cnt_d < (ratio_d >> 1));
        tick_d = run_d && (cnt_d == ratio_d - ONE);
    end

    always_ff @(posedge clk1 or posedge rst1) begin
        if (rst1) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            ratio_q    <= DEF_R;
            pend_q     <= DEF_R;
            pend_vld_q <= 1'b0;
            out1_q     <= 1'b0;
            tick_q     <= 1'b0;
            busy_q     <= 1'b0;
            ack_q      <= 1'b0;
        end else begin
            state_q    <= run_d ? RUN : IDLE;
            cnt_q      <= cnt_d;
            ratio_q    <= ratio_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            out1_q     <= out1_d;
            tick_q     <= tick_d;
            busy_q     <= run_d;
            ack_q      <= load;
        end
    end

    assign out1     = out1_q;
    assign tick     = tick_q;
    assign busy     = busy_q;
    assign load_ack = ack_q;

endmodule

// File: tb/tb_clk_div_gen.sv
// Self-checking bench for clk_div_gen: period-level reference model
// checked every cycle, plus hand-computed waveform snapshots.
module tb_clk_div_gen;

    localparam int DIV_W = 8;

    logic             clk1 = 1'b0;
    logic             rst1;
    logic             en = 1'b0;
    logic             load = 1'b0;
    logic [DIV_W-1:0] div_ratio = '0;
    logic             load_ack;
    logic             out1;
    logic             tick;
    logic             busy;

    int checks = 0;
    int errors = 0;

    clk_div_gen #(.DIV_W(DIV_W), .DEF_DIV(2)) dut (
        .clk1      (clk1),
        .rst1      (rst1),
        .en        (en),
        .div_ratio (div_ratio),
        .load      (load),
        .load_ack  (load_ack),
        .out1      (out1),
        .tick      (tick),
        .busy      (busy)
    );

    always #5 clk1 = ~clk1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: each period is expanded into a queue of
    // per-cycle (out1, tick) values when it starts.
    typedef struct packed {
        logic o;
        logic t;
    } ph_t;

    ph_t q[$];
    logic m_run = 1'b0;
    int   m_n   = 2;
    int   m_p   = 2;
    logic m_pv  = 1'b0;
    logic m_ack = 1'b0;

    task automatic start_period(input int n);
        for (int k = 0; k < n; k++) begin
            q.push_back({(k < n / 2), (k == n - 1)});
        end
    endtask

    initial begin
        forever begin
            logic bnd;
            @(posedge clk1 or posedge rst1);
            if (rst1) begin
                m_run = 1'b0;
                m_n   = 2;
                m_pv  = 1'b0;
                m_ack = 1'b0;
                q.delete();
            end else begin
                bnd = 1'b1;
                if (m_run) begin
                    void'(q.pop_front());
                    bnd = (q.size() == 0);
                end
                if (bnd) begin
                    if (m_pv) begin
                        m_n  = m_p;
                        m_pv = 1'b0;
                    end
                    if (en) begin
                        m_run = 1'b1;
                        start_period(m_n);
                    end else begin
                        m_run = 1'b0;
                    end
                end
                m_ack = load;
                if (load) begin
                    m_p  = (int'(div_ratio) < 2) ? 2 : int'(div_ratio);
                    m_pv = 1'b1;
                end
            end
        end
    end

    initial begin
        forever begin
            ph_t cur;
            @(negedge clk1);
            if (rst1 === 1'b0) begin
                cur = (m_run && q.size() > 0) ? q[0] : '0;
                chk("m_out1", 32'(out1), 32'(cur.o));
                chk("m_tick", 32'(tick), 32'(cur.t));
                chk("m_busy", 32'(busy), 32'(m_run));
                chk("m_ack", 32'(load_ack), 32'(m_ack));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1);
    end

    task automatic cap(input int n, output logic [31:0] o,
                       output logic [31:0] t, output logic [31:0] b);
        o = '0;
        t = '0;
        b = '0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk1);
            o = {o[30:0], out1};
            t = {t[30:0], tick};
            b = {b[30:0], busy};
        end
    endtask

    task automatic load_idle(input logic [DIV_W-1:0] r);
        load      = 1'b1;
        div_ratio = r;
        @(negedge clk1);
        load = 1'b0;
        @(negedge clk1);
    endtask

    initial begin
        logic [31:0] o, t, b;
        rst1 = 1'b1;
        @(negedge clk1);
        chk("rst_out1", 32'(out1), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_tick", 32'(tick), 0);
        chk("rst_ack", 32'(load_ack), 0);
        @(negedge clk1);
        rst1 = 1'b0;
        repeat (5) @(negedge clk1);
        chk("idle_busy", 32'(busy), 0);
        chk("idle_out1", 32'(out1), 0);

        // Default N=2
        en = 1'b1;
        cap(6, o, t, b);
        chk("def_out1", o, 32'b101010);
        chk("def_tick", t, 32'b010101);
        chk("def_busy", b, 32'b111111);
        en = 1'b0;
        repeat (3) @(negedge clk1);
        chk("def_stop", 32'(busy), 0);

        // Odd ratio N=5
        load      = 1'b1;
        div_ratio = 8'd5;
        @(negedge clk1);
        load = 1'b0;
        chk("ack_hi", 32'(load_ack), 1);
        @(negedge clk1);
        chk("ack_lo", 32'(load_ack), 0);
        en = 1'b1;
        cap(10, o, t, b);
        chk("odd_out1", o, 32'b1100011000);
        chk("odd_tick", t, 32'b0000100001);
        en = 1'b0;
        repeat (3) @(negedge clk1);

        // Ratio change at boundary: N=4 then 8, wrap-edge load of 6
        load_idle(8'd4);
        en = 1'b1;
        cap(2, o, t, b);
        chk("chg_k01", o, 32'b11);
        load      = 1'b1;
        div_ratio = 8'd8;
        @(negedge clk1);
        load = 1'b0;
        cap(13, o, t, b);
        chk("chg_4to8", o, 32'b0111100001111);
        repeat (4) @(negedge clk1);
        load      = 1'b1;
        div_ratio = 8'd6;
        @(negedge clk1);
        load = 1'b0;
        chk("wrap_k0", 32'(out1), 1);
        cap(15, o, t, b);
        chk("wrap_load", o, 32'b111000011100011);
        en = 1'b0;
        repeat (8) @(negedge clk1);

        // Clamp 0 and 1 to 2
        load_idle(8'd0);
        en = 1'b1;
        cap(6, o, t, b);
        chk("clamp0_out1", o, 32'b101010);
        chk("clamp0_tick", t, 32'b010101);
        en = 1'b0;
        repeat (3) @(negedge clk1);
        load_idle(8'd1);
        en = 1'b1;
        cap(6, o, t, b);
        chk("clamp1_out1", o, 32'b101010);
        chk("clamp1_tick", t, 32'b010101);
        en = 1'b0;
        repeat (3) @(negedge clk1);

        // Stop mid-period with N=6
        load_idle(8'd6);
        en = 1'b1;
        cap(2, o, t, b);
        chk("stop_k01", o, 32'b11);
        en = 1'b0;
        cap(8, o, t, b);
        chk("stop_out1", o, 32'b10000000);
        chk("stop_busy", b, 32'b11110000);
        chk("stop_tick", t, 32'b00010000);
        en = 1'b1;
        cap(3, o, t, b);
        chk("restart", o, 32'b111);
        chk("restart_busy", b, 32'b111);

        // Asynchronous reset mid-period at cnt=2
        #2;
        rst1 = 1'b1;
        en   = 1'b0;
        #1;
        chk("arst_out1", 32'(out1), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_tick", 32'(tick), 0);
        @(negedge clk1);
        rst1 = 1'b0;
        repeat (10) @(negedge clk1);
        chk("post_out1", 32'(out1), 0);
        chk("post_busy", 32'(busy), 0);
        chk("post_tick", 32'(tick), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
